// File: rtl/ec1_datapath_if.sv
// Control/data bundle between the EC-1 control unit (master) and its datapath (slave).
// Signal names follow the original control-unit naming so the two sides line up one-to-one.
interface ec1_datapath_if;
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [1:0] Asel;
    logic [7:0] Input;
    logic       ProgWe;
    logic [4:0] ProgAddr;
    logic [7:0] ProgData;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic [7:0] Output;
    logic [4:0] PC;

    modport master (
        output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt,
        output Asel, Input, ProgWe, ProgAddr, ProgData,
        input  IR, Aeq0, Apos, Output, PC
    );

    modport slave (
        input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt,
        input  Asel, Input, ProgWe, ProgAddr, ProgData,
        output IR, Aeq0, Apos, Output, PC
    );
endinterface

// File: rtl/ec1_datapath.sv
// EC-1 accumulator datapath: 32x8 memory, PC, instruction register, A register and add/sub ALU.
// Strobes from the control unit are applied at the rising edge; Reset wins over everything but program load.
module ec1_datapath (
    input  logic          Clock,
    input  logic          Reset,
    ec1_datapath_if.slave bus
);
    typedef enum logic [1:0] {
        ASEL_ALU   = 2'b00,
        ASEL_INPUT = 2'b01,
        ASEL_MEM   = 2'b10,
        ASEL_ZERO  = 2'b11
    } asel_e;

    logic [7:0] mem_q [32];
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;

    logic [4:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] alu_result;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;

    assign mem_addr   = bus.Meminst ? pc_q : ir_q[4:0];
    assign mem_rdata  = mem_q[mem_addr];
    assign alu_result = bus.Sub ? (a_q - mem_rdata) : (a_q + mem_rdata);

    always_comb begin
        // NOTE: every next-state signal starts from its hold value so no path leaves it unassigned (no latch).
        pc_d = pc_q;
        ir_d = ir_q;
        a_d  = a_q;
        if (!bus.Halt) begin
            if (bus.IRload) ir_d = mem_rdata;
            if (bus.PCload) pc_d = bus.JMPmux ? ir_q[4:0] : pc_q + 5'd1;
            if (bus.Aload) begin
                case (asel_e'(bus.Asel))
                    ASEL_ALU:   a_d = alu_result;
                    ASEL_INPUT: a_d = bus.Input;
                    ASEL_MEM:   a_d = mem_rdata;
                    ASEL_ZERO:  a_d = 8'h00;
                    default:    a_d = a_q;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q <= 5'd0;
            ir_q <= 8'h00;
            a_q  <= 8'h00;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
        end
    end

    // Program load owns the write port; a datapath store in the same cycle is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = mem_addr;
        mem_wdata = a_q;
        if (bus.ProgWe) begin
            mem_we    = 1'b1;
            mem_waddr = bus.ProgAddr;
            mem_wdata = bus.ProgData;
        end else if (bus.MemWr && !bus.Halt && !Reset) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the memory array has no reset; program contents must survive a Reset.
    always_ff @(posedge Clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.IR     = ir_q[7:5];
    assign bus.PC     = pc_q;
    assign bus.Output = a_q;
    assign bus.Aeq0   = (a_q == 8'h00);
    assign bus.Apos   = !a_q[7] && (a_q != 8'h00);
endmodule

// File: tb/tb_ec1_datapath.sv
// Directed and random stimulus for ec1_datapath, checked against an integer-arithmetic reference model.
module tb_ec1_datapath;
    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    int   m_mem [32];
    int   m_pc;
    int   m_ir;
    int   m_a;

    ec1_datapath_if bus ();

    ec1_datapath dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Reset        = 1'b0;
        bus.IRload   = 1'b0;
        bus.PCload   = 1'b0;
        bus.JMPmux   = 1'b0;
        bus.Meminst  = 1'b0;
        bus.MemWr    = 1'b0;
        bus.Aload    = 1'b0;
        bus.Sub      = 1'b0;
        bus.Halt     = 1'b0;
        bus.Asel     = 2'b00;
        bus.Input    = 8'h00;
        bus.ProgWe   = 1'b0;
        bus.ProgAddr = 5'd0;
        bus.ProgData = 8'h00;
    endtask

    // Advances one clock: predicts the architectural effect of the current inputs, then compares.
    task automatic step(input string tag);
        int addr, md, na, npc, nir;
        addr = bus.Meminst ? m_pc : (m_ir % 32);
        md   = m_mem[addr];
        na   = m_a;
        npc  = m_pc;
        nir  = m_ir;
        if (Reset) begin
            na  = 0;
            npc = 0;
            nir = 0;
        end else if (!bus.Halt) begin
            if (bus.IRload) nir = md;
            if (bus.PCload) npc = bus.JMPmux ? (m_ir % 32) : (m_pc + 1) % 32;
            if (bus.Aload) begin
                if (bus.Asel == 2'd0)      na = bus.Sub ? (m_a - md + 256) % 256 : (m_a + md) % 256;
                else if (bus.Asel == 2'd1) na = int'(bus.Input);
                else if (bus.Asel == 2'd2) na = md;
                else                       na = 0;
            end
        end
        if (bus.ProgWe) m_mem[int'(bus.ProgAddr)] = int'(bus.ProgData);
        else if (bus.MemWr && !bus.Halt && !Reset) m_mem[addr] = m_a;
        @(posedge Clock);
        #1;
        m_a  = na;
        m_pc = npc;
        m_ir = nir;
        check({tag, ".Output"}, bus.Output, 8'(m_a));
        check({tag, ".PC"}, {3'b000, bus.PC}, 8'(m_pc));
        check({tag, ".IR"}, {5'b00000, bus.IR}, 8'(m_ir / 32));
        check({tag, ".Aeq0"}, {7'd0, bus.Aeq0}, (m_a == 0) ? 8'd1 : 8'd0);
        check({tag, ".Apos"}, {7'd0, bus.Apos}, (m_a > 0 && m_a < 128) ? 8'd1 : 8'd0);
    endtask

    task automatic prog(input logic [4:0] addr, input logic [7:0] data);
        idle();
        bus.ProgWe   = 1'b1;
        bus.ProgAddr = addr;
        bus.ProgData = data;
        step("prog");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pc   = 0;
        m_ir   = 0;
        m_a    = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        Clock  = 1'b0;
        idle();

        // Reset with Halt and other strobes active, plus a program write that must still land
        Reset        = 1'b1;
        bus.Halt     = 1'b1;
        bus.Aload    = 1'b1;
        bus.Asel     = 2'b01;
        bus.Input    = 8'h77;
        bus.PCload   = 1'b1;
        bus.ProgWe   = 1'b1;
        bus.ProgAddr = 5'd0;
        bus.ProgData = 8'h5C;
        step("reset");
        check("reset_out", bus.Output, 8'h00);
        check("reset_pc", {3'b000, bus.PC}, 8'h00);
        check("reset_ir", {5'b00000, bus.IR}, 8'h00);
        check("reset_aeq0", {7'd0, bus.Aeq0}, 8'd1);
        check("reset_apos", {7'd0, bus.Apos}, 8'd0);

        for (int i = 1; i < 32; i++) prog(5'(i), 8'($urandom));

        // Fetch then load A from memory
        prog(5'd0, 8'h03);
        prog(5'd3, 8'h05);
        idle(); bus.Meminst = 1'b1; bus.IRload = 1'b1; bus.PCload = 1'b1;
        step("fetch");
        check("fetch_ir", {5'b00000, bus.IR}, 8'h00);
        check("fetch_pc", {3'b000, bus.PC}, 8'h01);
        idle(); bus.Asel = 2'b10; bus.Aload = 1'b1;
        step("lda");
        check("lda_out", bus.Output, 8'h05);
        check("lda_apos", {7'd0, bus.Apos}, 8'd1);

        // Subtract to a negative value, then add back
        prog(5'd3, 8'h07);
        idle(); bus.Sub = 1'b1; bus.Aload = 1'b1;
        step("sub");
        check("sub_out", bus.Output, 8'hFE);
        check("sub_apos", {7'd0, bus.Apos}, 8'd0);
        check("sub_aeq0", {7'd0, bus.Aeq0}, 8'd0);
        idle(); bus.Aload = 1'b1;
        step("add");
        check("add_out", bus.Output, 8'h05);

        // Jump target from IR and PC wrap
        prog(5'd1, 8'hB4);
        idle(); bus.Meminst = 1'b1; bus.IRload = 1'b1;
        step("ld_b4");
        idle(); bus.PCload = 1'b1; bus.JMPmux = 1'b1;
        step("jmp");
        check("jmp_pc", {3'b000, bus.PC}, 8'h14);
        prog(5'h14, 8'h1F);
        idle(); bus.Meminst = 1'b1; bus.IRload = 1'b1;
        step("ld_1f");
        idle(); bus.PCload = 1'b1; bus.JMPmux = 1'b1;
        step("jmp31");
        check("jmp31_pc", {3'b000, bus.PC}, 8'h1F);
        idle(); bus.PCload = 1'b1;
        step("wrap");
        check("wrap_pc", {3'b000, bus.PC}, 8'h00);

        // Store A, same-cycle read sees old data, program write beats store
        idle(); bus.Aload = 1'b1; bus.Asel = 2'b01; bus.Input = 8'h2A;
        step("in2a");
        prog(5'd0, 8'h09);
        idle(); bus.Meminst = 1'b1; bus.IRload = 1'b1;
        step("ld_09");
        idle(); bus.MemWr = 1'b1; bus.Aload = 1'b1; bus.Asel = 2'b10;
        step("sta_old");
        idle(); bus.Aload = 1'b1; bus.Asel = 2'b11;
        step("clr");
        check("clr_aeq0", {7'd0, bus.Aeq0}, 8'd1);
        idle(); bus.Aload = 1'b1; bus.Asel = 2'b10;
        step("rd9");
        check("rd9_out", bus.Output, 8'h2A);
        idle(); bus.MemWr = 1'b1; bus.ProgWe = 1'b1; bus.ProgAddr = 5'd9; bus.ProgData = 8'h11;
        step("wr_conflict");
        idle(); bus.Aload = 1'b1; bus.Asel = 2'b10;
        step("rd9b");
        check("rd9b_out", bus.Output, 8'h11);

        // Halt freezes datapath updates; Reset still wins
        idle(); bus.Halt = 1'b1; bus.Aload = 1'b1; bus.Asel = 2'b01; bus.Input = 8'h33;
        bus.IRload = 1'b1; bus.PCload = 1'b1; bus.MemWr = 1'b1;
        step("halt");
        check("halt_out", bus.Output, 8'h11);
        idle(); bus.Halt = 1'b1; Reset = 1'b1;
        step("halt_reset");
        check("halt_reset_out", bus.Output, 8'h00);
        check("halt_reset_pc", {3'b000, bus.PC}, 8'h00);

        // Random instruction soup
        for (int i = 0; i < 400; i++) begin
            idle();
            Reset        = ($urandom_range(0, 24) == 0);
            bus.Halt     = ($urandom_range(0, 3) == 0);
            bus.IRload   = 1'($urandom);
            bus.PCload   = 1'($urandom);
            bus.JMPmux   = 1'($urandom);
            bus.Meminst  = 1'($urandom);
            bus.MemWr    = !Reset && ($urandom_range(0, 2) == 0);
            bus.Aload    = 1'($urandom);
            bus.Sub      = 1'($urandom);
            bus.Asel     = 2'($urandom);
            bus.Input    = 8'($urandom);
            bus.ProgWe   = ($urandom_range(0, 3) == 0);
            bus.ProgAddr = 5'($urandom);
            bus.ProgData = 8'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
